// File: rtl/qsn_rotate_pipe.sv
// -----------------------------------------------------------------------------
// qsn_rotate_pipe
//
// Purpose
//   Two-stage pipelined cyclic column rotator, as used in QC-LDPC decoders.
//   The input word holds PC columns of Q bits each. Column c is at bits
//   [c*Q +: Q]. For the effective shift s, output column j receives input
//   column (j + s) mod PC. All Q bits of a column move together.
//
//   Effective shift:
//     in_dir = 0 (left)  : s = in_shift
//     in_dir = 1 (right) : s = (in_shift == 0) ? 0 : PC - in_shift
//
// Optional feature (compile-time macro QSN_RANGE_CHECK_EN)
//   defined   : in_shift >= PC flags out_err = 1 for that beat, and the data
//               goes through unrotated (s = 0) whatever in_dir says.
//   undefined : out_err is always 0. in_shift >= PC is reduced once to
//               in_shift - PC before the direction is applied. One reduction
//               is enough because 2**SW < 2*PC.
//
// Pipeline
//   stage 1 : registers the decoded shift and two zero-filled partial
//             shifts of the input word. lo = in >> s columns, hi = in <<
//             (PC - s) columns.
//   stage 2 : merges lo (columns j < PC-s) and hi (columns j >= PC-s)
//             onto out_data.
//   Latency is 2 cycles from accept to out_valid when nothing stalls.
//
// Handshake (valid/ready)
//   A beat moves across an interface on a rising edge where valid & ready
//   are both high. A producer holding valid keeps its payload stable until
//   the beat is taken. stall = out_valid & ~out_ready freezes the whole
//   pipe. in_ready = ~stall is combinational from out_ready. Bubbles move
//   through as valid = 0 and never raise out_valid.
//
// Ports
//   sys_clk   in   1      clock, all state on the rising edge
//   rstn      in   1      async assert, active-low reset
//   in_valid  in   1      input beat valid
//   in_ready  out  1      block accepts a beat this cycle
//   in_data   in   PC*Q   input columns
//   in_shift  in   SW     rotation amount
//   in_dir    in   1      0 = left, 1 = right
//   out_valid out  1      output beat valid
//   out_ready in   1      downstream accepts beat
//   out_data  out  PC*Q   rotated columns
//   out_err   out  1      shift out of range (range-check build only)
// -----------------------------------------------------------------------------
module qsn_rotate_pipe #(
  parameter int PC = 51,
  parameter int Q  = 3,
  parameter int SW = $clog2(PC)
) (
  input  logic            sys_clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC*Q-1:0] in_data,
  input  logic [SW-1:0]   in_shift,
  input  logic            in_dir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC*Q-1:0] out_data,
  output logic            out_err
);

  localparam int W = PC * Q;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Shift decode (combinational, in front of stage 1)
  // ---------------------------------------------------------------------------
  logic [31:0]   shift_ext;
  logic          shift_oor;
  logic [31:0]   shift_red;
  logic [SW-1:0] eff_shift;
  logic          dec_err;

  assign shift_ext = 32'(in_shift);
  assign shift_oor = (shift_ext >= 32'(PC));

  always_comb begin
    dec_err   = 1'b0;
    shift_red = shift_ext;
`ifdef QSN_RANGE_CHECK_EN
    // An out-of-range shift passes the data through untouched and flags it.
    if (shift_oor) begin
      dec_err   = 1'b1;
      shift_red = 32'd0;
    end
`else
    // One subtraction is enough, because the shift field cannot reach 2*PC.
    if (shift_oor) begin
      shift_red = shift_ext - 32'(PC);
    end
`endif
    // A right rotation by r is the same as a left rotation by PC - r.
    // A zero shift maps to zero so that s stays within 0..PC-1.
    if (in_dir && (shift_red != 32'd0)) begin
      eff_shift = SW'(32'(PC) - shift_red);
    end else begin
      eff_shift = SW'(shift_red);
    end
  end

  // ---------------------------------------------------------------------------
  // Partial shifts (combinational, in front of stage 1)
  //   part_lo : column j holds in column j+s     for j <  PC-s, zero above.
  //   part_hi : column j holds in column j+s-PC  for j >= PC-s, zero below.
  //   When s = 0 the hi shift equals the full width, so part_hi is all zero.
  // ---------------------------------------------------------------------------
  logic [31:0]  lo_amt;
  logic [31:0]  hi_amt;
  logic [W-1:0] part_lo;
  logic [W-1:0] part_hi;

  assign lo_amt  = 32'(eff_shift) * 32'(Q);
  assign hi_amt  = (32'(PC) - 32'(eff_shift)) * 32'(Q);
  assign part_lo = in_data >> lo_amt;
  assign part_hi = in_data << hi_amt;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [SW-1:0] s1_shift;
  logic [W-1:0]  s1_lo;
  logic [W-1:0]  s1_hi;
  logic          s1_err;

  // ---------------------------------------------------------------------------
  // Merge (combinational, in front of stage 2)
  //   The mask selects the columns that come from part_lo. The partials are
  //   already zero-filled, so a plain OR would also work. The mask keeps the
  //   merge correct even if a partial carries stray bits.
  // ---------------------------------------------------------------------------
  logic [31:0]  mask_amt;
  logic [W-1:0] lo_mask;
  logic [W-1:0] merged;

  assign mask_amt = 32'(s1_shift) * 32'(Q);
  assign lo_mask  = {W{1'b1}} >> mask_amt;
  assign merged   = (s1_lo & lo_mask) | (s1_hi & ~lo_mask);

  // ---------------------------------------------------------------------------
  // Pipeline state
  //   A stall freezes every register. Otherwise both valids advance each
  //   cycle, so bubbles propagate. Payload registers load only when a real
  //   beat arrives, so out_data/out_err change only on a stage-2 load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_shift  <= '0;
      s1_lo     <= '0;
      s1_hi     <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_shift <= eff_shift;
        s1_lo    <= part_lo;
        s1_hi    <= part_hi;
        s1_err   <= dec_err;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= merged;
        out_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_qsn_rotate_pipe.sv
// -----------------------------------------------------------------------------
// tb_qsn_rotate_pipe
//   Directed table of single beats with hand-computed columns, a back-pressure
//   sequence, a mid-stream reset, and a long random stream checked against a
//   column-indexing reference model through an expected queue.
//   Build with or without QSN_RANGE_CHECK_EN. The expectations follow the
//   macro.
// -----------------------------------------------------------------------------
module tb_qsn_rotate_pipe;

  localparam int PC = 51;
  localparam int Q  = 3;
  localparam int SW = 6;
  localparam int W  = PC * Q;

  logic          sys_clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;

  qsn_rotate_pipe #(.PC(PC), .Q(Q)) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: direct column indexing from the rotation definition.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int shift,
                                         input logic dir, output logic err);
    logic [W-1:0] r;
    int sh;
    int s;
    err = 1'b0;
    sh  = shift;
`ifdef QSN_RANGE_CHECK_EN
    if (sh >= PC) begin
      err = 1'b1;
      return d;
    end
`else
    if (sh >= PC) sh = sh - PC;
`endif
    s = dir ? ((sh == 0) ? 0 : PC - sh) : sh;
    r = '0;
    for (int j = 0; j < PC; j++) r[j*Q +: Q] = d[((j + s) % PC)*Q +: Q];
    return r;
  endfunction

  function automatic int col(input logic [W-1:0] d, input int j);
    return int'(d[j*Q +: Q]);
  endfunction

  function automatic logic [W-1:0] pat_mod8();
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < PC; c++) r[c*Q +: Q] = 3'(c % 8);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < PC; c++) r[c*Q +: Q] = 3'($urandom_range(0, 7));
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table (data = column c holds c mod 8)
  // ---------------------------------------------------------------------------
  typedef struct {
    int   shift;
    logic dir;
    int   c0;
    int   c1;
    int   c50;
    logic err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic fill_vecs();
    vecs[0] = '{1,  1'b0, 1, 2, 0, 1'b0};
    vecs[1] = '{1,  1'b1, 2, 0, 1, 1'b0};
    vecs[2] = '{0,  1'b0, 0, 1, 2, 1'b0};
    vecs[3] = '{0,  1'b1, 0, 1, 2, 1'b0};
    vecs[4] = '{10, 1'b0, 2, 3, 1, 1'b0};
    vecs[5] = '{10, 1'b1, 1, 2, 0, 1'b0};
    vecs[6] = '{50, 1'b0, 2, 0, 1, 1'b0};
    vecs[7] = '{25, 1'b1, 2, 3, 1, 1'b0};
`ifdef QSN_RANGE_CHECK_EN
    vecs[8] = '{55, 1'b0, 0, 1, 2, 1'b1};
    vecs[9] = '{63, 1'b1, 0, 1, 2, 1'b1};
`else
    vecs[8] = '{55, 1'b0, 4, 5, 3, 1'b0};
    vecs[9] = '{63, 1'b1, 7, 0, 6, 1'b0};
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = '0;
    in_shift = '0;
    in_dir   = 1'b0;
  endtask

  // One beat in an empty pipe. Checks the exact 2-cycle latency and the result.
  task automatic apply_vec(input int i);
    logic [W-1:0] pat;
    logic [W-1:0] exp_d;
    logic         exp_e;
    pat = pat_mod8();
    @(negedge sys_clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pat;
    in_shift  = SW'(vecs[i].shift);
    in_dir    = vecs[i].dir;
    #1;
    check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(1));
    @(negedge sys_clk);
    idle_inputs();
    #1;
    check($sformatf("vec%0d_lat1_valid", i), W'(out_valid), W'(0));
    @(negedge sys_clk);
    #1;
    check($sformatf("vec%0d_lat2_valid", i), W'(out_valid), W'(1));
    check($sformatf("vec%0d_c0", i),  W'(col(out_data, 0)),  W'(vecs[i].c0));
    check($sformatf("vec%0d_c1", i),  W'(col(out_data, 1)),  W'(vecs[i].c1));
    check($sformatf("vec%0d_c50", i), W'(col(out_data, 50)), W'(vecs[i].c50));
    check($sformatf("vec%0d_err", i), W'(out_err), W'(vecs[i].err));
    exp_d = model(pat, vecs[i].shift, vecs[i].dir, exp_e);
    check($sformatf("vec%0d_full", i), out_data, exp_d);
  endtask

  // Streaming driver and scoreboard. mode 0 is the back-pressure sequence:
  // shifts 0..9, out_ready low in cycles 3..6. mode 1 is random traffic.
  task automatic run_stream(input int mode, input int nbeats, input int max_cyc);
    int sent;
    int got;
    int cyc;
    logic [W-1:0] d;
    logic [W-1:0] exp_d;
    logic         exp_e;
    logic         e_tmp;
    int           sh;
    logic         dr;
    sent = 0;
    got  = 0;
    cyc  = 0;
    d    = (mode == 0) ? pat_mod8() : rand_data();
    sh   = (mode == 0) ? 0 : int'($urandom_range(0, 63));
    dr   = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    while ((sent < nbeats || got < nbeats) && cyc < max_cyc) begin
      @(negedge sys_clk);
      if (mode == 0) begin
        out_ready = !(cyc >= 3 && cyc <= 6);
        in_valid  = (sent < nbeats);
      end else begin
        out_ready = ($urandom_range(0, 99) < 70);
        if (!in_valid || sent >= nbeats)
          in_valid = (sent < nbeats) && ($urandom_range(0, 99) < 70);
      end
      in_data  = d;
      in_shift = SW'(sh);
      in_dir   = dr;
      #1;
      if (mode == 0 && cyc >= 3 && cyc <= 6)
        check($sformatf("bp_in_ready_c%0d", cyc), W'(in_ready), W'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious_beat", W'(1), W'(0));
        end else begin
          exp_d = exp_q.pop_front();
          exp_e = exp_err_q.pop_front();
          check($sformatf("stream_data_b%0d", got), out_data, exp_d);
          check($sformatf("stream_err_b%0d", got), W'(out_err), W'(exp_e));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(d, sh, dr, e_tmp));
        exp_err_q.push_back(e_tmp);
        sent++;
        if (mode == 0) begin
          sh = sent;
        end else begin
          d  = rand_data();
          sh = int'($urandom_range(0, 63));
          dr = 1'($urandom_range(0, 1));
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    check($sformatf("stream%0d_beats_out", mode), W'(got), W'(nbeats));
    check($sformatf("stream%0d_queue_empty", mode), W'(exp_q.size()), W'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rstn      = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    fill_vecs();
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data",  out_data,      W'(0));
    check("rst_out_err",   W'(out_err),   W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    repeat (3) @(negedge sys_clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) apply_vec(i);

    run_stream(0, 10, 60);

    // Mid-stream reset: two beats in flight, output stalled.
    @(negedge sys_clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pat_mod8();
    in_shift  = SW'(3);
    in_dir    = 1'b0;
    @(negedge sys_clk);
    in_shift  = SW'(7);
    @(negedge sys_clk);
    idle_inputs();
    #1;
    check("mrst_pre_valid", W'(out_valid), W'(1));
    #1;
    rstn = 1'b0;
    #1;
    check("mrst_out_valid", W'(out_valid), W'(0));
    check("mrst_out_data",  out_data,      W'(0));
    check("mrst_out_err",   W'(out_err),   W'(0));
    check("mrst_in_ready",  W'(in_ready),  W'(1));
    @(negedge sys_clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      #1;
      check($sformatf("mrst_no_stale_c%0d", k), W'(out_valid), W'(0));
    end

    run_stream(1, 10000, 60000);

    // Idle: nothing may come out once the pipe is drained.
    out_ready = 1'b1;
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      #1;
      check($sformatf("idle_valid_c%0d", k), W'(out_valid), W'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
